// File: rtl/fifo_burst_pkg.sv
// Shared types and constants for the burst-mode FIFO read controller.
// Imported by the controller top and its output buffer.
package fifo_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BCNT_W = 16;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry {last, data} buffer that absorbs the FIFO read latency.
// Entry 0 is always the head; entry 1 is only used when two words are held.
module fifo_skid2
    import fifo_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] data1;
    logic                  last1;
    logic                  do_pop;
    logic                  do_push;

    assign do_pop  = pop && (occ != 2'd0);
    assign do_push = push && ((occ != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_data <= '0;
            head_last <= 1'b0;
            data1     <= '0;
            last1     <= 1'b0;
            occ       <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        data1 <= push_data;
                        last1 <= push_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= data1;
                    head_last <= last1;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop: occupancy holds, contents shift.
                    if (occ == 2'd1) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        head_data <= data1;
                        head_last <= last1;
                        data1     <= push_data;
                        last1     <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a registered-output FIFO in fixed bursts onto a valid/ready stream.
// Reads are throttled so buffered plus in-flight words never exceed two.
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 6,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [CNT_W-1:0]      fifo_count,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic [BCNT_W-1:0]     burst_count
);

    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_nx;
    logic             inflight;
    logic             inflight_last;
    logic [1:0]       occ;
    logic             pop;
    logic [2:0]       pending;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign busy    = (state != IDLE);

    // Words that will occupy the buffer after this edge, excluding a new read.
    assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = (state == BURST) && (remaining != '0)
                        && !fifo_empty && (pending < 3'd2);

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        unique case (state)
            IDLE: begin
                if (fifo_count >= BURST_LEN_C) begin
                    state_nx     = BURST;
                    remaining_nx = BURST_LEN_C;
                end else if (flush && !fifo_empty) begin
                    state_nx     = BURST;
                    remaining_nx = fifo_count;
                end
            end
            BURST: begin
                if (fifo_rd_en) begin
                    remaining_nx = remaining - CNT_W'(1);
                end
                if (remaining_nx == '0) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            burst_count   <= '0;
        end else begin
            state         <= state_nx;
            remaining     <= remaining_nx;
            inflight      <= fifo_rd_en;
            inflight_last <= fifo_rd_en && (remaining == CNT_W'(1));
            if (pop && m_last) begin
                burst_count <= burst_count + BCNT_W'(1);
            end
        end
    end

    fifo_skid2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_last(inflight_last),
        .push_data(fifo_data),
        .pop      (pop),
        .head_data(m_data),
        .head_last(m_last),
        .occ      (occ)
    );

endmodule
